mf8_io_uart: RTL and testbench
==============================

// Module: mf8_io_uart
// PURPOSE
//  IO-bus peripheral directly downstream of the mf8 core's IO port: 8N1 UART with TX/RX FIFOs.
//  Decodes IO_Addr/IO_Rd/IO_Wr from the core and returns IO_RData in the same cycle as IO_Rd.
//  Four registers in a 4-byte window at BASE_ADDR: UDR (data), USR (status), UBRL/UBRH (bit divisor).
// PARAMETERS
//  BASE_ADDR  6'h0C   IO address of UDR; window is BASE_ADDR..BASE_ADDR+3, BASE_ADDR[1:0] must be 0
//  FIFO_AW    2       FIFO address width; depth = 2**FIFO_AW per direction
//  DIV_RST    16'd433 reset divisor; bit period = DIV+1 Clk cycles
// PORTS
//  Clk        in   1   system clock, all state on rising edge
//  Reset_n    in   1   asynchronous active-low reset
//  IO_Rd      in   1   core read strobe, one cycle, registered in core
//  IO_Wr      in   1   core write strobe, one cycle, registered in core
//  IO_Addr    in   6   IO register address
//  IO_WData   in   8   write data, valid while IO_Wr=1
//  IO_RData   out  8   read data, combinational from IO_Addr; 8'h00 outside window
//  uart_rxd   in   1   serial input, asynchronous
//  uart_txd   out  1   serial output, idle high
//  uart_irq   out  1   registered: RXNE | (TXIE & TXIDLE)
// BEHAVIOUR
//  Reset: uart_txd=1, uart_irq=0, both FIFOs empty, TX/RX FSMs IDLE, DIV=DIV_RST, sticky flags=0, TXIE=0.
//  Register map (offset): 0 UDR, 1 USR, 2 UBRL=DIV[7:0], 3 UBRH=DIV[15:8]. Other addresses: no effect, read 0.
//  UDR write: push TX FIFO; if full, data dropped and TXOVF set. UDR read: returns RX head
//   (8'h00 if empty) in the IO_Rd cycle; pop on the closing edge only if not empty.
//  USR read: [0]RXNE [1]TXNF [2]TXIDLE (FIFO empty & TX FSM IDLE) [3]RXOVF [4]FERR [5]TXOVF [6]TXIE [7]0.
//  USR write: bits 3,4,5 write-1-to-clear; bit 6 writes TXIE; other bits ignored.
//  UBRL/UBRH write: update DIV immediately; running bit timers use the new value from next reload.
//  IO_RData is pure combinational (core samples it in the IO_Rd cycle); no wait states, no side effect w/o IO_Rd.
//  TX FSM: IDLE->START when FIFO non-empty (pop on that edge, load shifter); START 1 bit of 0;
//   DATA 8 bits LSB first; STOP 1 bit of 1; STOP->START directly if FIFO non-empty else IDLE.
//   Back-to-back frames have no idle gap. Bit timer counts DIV..0, reloads on 0.
//  RX: uart_rxd through 2-flop synchroniser (reset value 1). FSM IDLE->START on synced falling level;
//   START samples at (DIV>>1): if 1 -> IDLE (glitch), else DATA; DATA samples 8 bits each DIV+1 later, LSB first;
//   STOP samples once: 1 -> push byte; 0 -> set FERR, byte discarded; then IDLE (re-arms same cycle).
//   Push into full RX FIFO: byte dropped, RXOVF set, FIFO content unchanged.
//  Simultaneous: UDR read pop and RX push same edge on full FIFO -> both succeed (count unchanged).
//   TX FIFO push by core and pop by FSM same edge -> both succeed. Sticky set and W1C same edge -> set wins.
//  FIFO pointers FIFO_AW+1 bits, wrap modulo 2**(FIFO_AW+1); full = MSB differ & rest equal.
//  Reset asserted mid-frame: txd forced 1 asynchronously, frames abandoned, FIFOs flushed.
// STRUCTURE
//  mf8_io_defs.vh: register offsets, USR bit indices, FSM state encodings (IDLE/START/DATA/STOP).
//  Sub-module mf8_fifo (sync FIFO, params W=8, AW; ports push/pop/din/dout/empty/full, show-ahead dout),
//   instantiated twice (TX, RX). Address decode, registers, TX FSM, RX FSM in this module.
// TESTING
//  Reset, then read USR -> 8'h06 (TXNF, TXIDLE); read UBRL/UBRH -> 8'hB1/8'h01; txd=1.
//  DIV=3, write UDR 8'hA5 -> txd: 0,1,0,1,0,0,1,0,1,1 each held 4 Clk; USR[2]=0 during, 1 after stop bit.
//  DIV=3, write 5 bytes back-to-back with FIFO_AW=2 -> 1st enters shifter, 4 in FIFO, none dropped;
//   6th immediate write sets TXOVF; 5 frames with no idle gap; W1C 8'h20 clears TXOVF.
//  DIV=7, drive rxd frame 8'h3C -> USR[0]=1; UDR read returns 8'h3C, next USR read RXNE=0.
//  Drive 5 RX frames with no reads (depth 4) -> RXOVF=1, reads return first 4 bytes in order, then 8'h00.
//  Drive frame with stop bit 0 -> FERR=1, RXNE=0; 1-clock low glitch on rxd -> no state change.

Source files
------------

// File: rtl/mf8_io_uart_pkg.sv
// mf8_io_uart_pkg: shared definitions for the mf8 IO-bus UART.
// Contents: register offsets, USR bit indices, the USR layout as a packed
// struct, and the serial FSM state encoding shared by the TX and RX engines.
package mf8_io_uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  // Register offsets within the 4-byte window
  localparam logic [1:0] OFF_UDR  = 2'd0;
  localparam logic [1:0] OFF_USR  = 2'd1;
  localparam logic [1:0] OFF_UBRL = 2'd2;
  localparam logic [1:0] OFF_UBRH = 2'd3;

  // USR bit indices
  localparam int unsigned USR_RXNE   = 0;
  localparam int unsigned USR_TXNF   = 1;
  localparam int unsigned USR_TXIDLE = 2;
  localparam int unsigned USR_RXOVF  = 3;
  localparam int unsigned USR_FERR   = 4;
  localparam int unsigned USR_TXOVF  = 5;
  localparam int unsigned USR_TXIE   = 6;

  // USR as seen on IO_RData, MSB first
  typedef struct packed {
    logic rsvd;
    logic txie;
    logic txovf;
    logic ferr;
    logic rxovf;
    logic txidle;
    logic txnf;
    logic rxne;
  } usr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mf8_io_uart_fifo.sv
// mf8_io_uart_fifo: synchronous show-ahead FIFO, depth 2**AW.
// Ports: Clk, Reset_n (async flush), push/din, pop/dout (head, valid when
// !empty), empty, full. A push into a full FIFO is accepted only when a pop
// happens on the same edge; a pop on an empty FIFO is ignored.
module mf8_io_uart_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointers wrap modulo 2**(AW+1); the extra MSB separates full from empty
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: content is only visible through the pointers
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mf8_io_uart.sv
// mf8_io_uart: 8N1 UART on the mf8 IO bus with TX/RX FIFOs.
// Ports: Clk, Reset_n (async, active low); IO_Rd/IO_Wr/IO_Addr/IO_WData from
// the core, IO_RData back (combinational, same cycle as IO_Rd); uart_rxd
// (asynchronous serial in), uart_txd (serial out, idle high), uart_irq
// (registered RXNE | (TXIE & TXIDLE)).
// Registers at BASE_ADDR+: 0 UDR, 1 USR, 2 UBRL, 3 UBRH. Bit period DIV+1 Clk.
module mf8_io_uart
  import mf8_io_uart_pkg::*;
#(
  parameter logic [5:0]  BASE_ADDR = 6'h0C,
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [15:0] DIV_RST   = 16'd433
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        IO_Rd,
  input  logic        IO_Wr,
  input  logic [5:0]  IO_Addr,
  input  logic [7:0]  IO_WData,
  output logic [7:0]  IO_RData,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        uart_irq
);

  // Address decode
  logic       sel;
  logic [1:0] off;
  logic       wr_udr, wr_usr, wr_ubrl, wr_ubrh, rd_udr;

  assign sel     = (IO_Addr[5:2] == BASE_ADDR[5:2]);
  assign off     = IO_Addr[1:0];
  assign wr_udr  = IO_Wr & sel & (off == OFF_UDR);
  assign wr_usr  = IO_Wr & sel & (off == OFF_USR);
  assign wr_ubrl = IO_Wr & sel & (off == OFF_UBRL);
  assign wr_ubrh = IO_Wr & sel & (off == OFF_UBRH);
  assign rd_udr  = IO_Rd & sel & (off == OFF_UDR);

  logic [DIV_W-1:0]  div;
  logic              txie, rxovf, ferr, txovf;

  // FIFOs
  logic [DATA_W-1:0] tx_dout, rx_dout, rx_shift;
  logic              tx_empty, tx_full, tx_pop;
  logic              rx_empty, rx_full, rx_pop, rx_push;

  mf8_io_uart_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
    .Clk(Clk), .Reset_n(Reset_n), .push(wr_udr), .pop(tx_pop),
    .din(IO_WData), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  mf8_io_uart_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
    .Clk(Clk), .Reset_n(Reset_n), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  // TX engine
  uart_state_t       tx_state;
  logic [DIV_W-1:0]  tx_timer;
  logic [2:0]        tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_idle;

  assign tx_pop  = ~tx_empty & ((tx_state == ST_IDLE) |
                                ((tx_state == ST_STOP) & (tx_timer == '0)));
  assign tx_idle = tx_empty & (tx_state == ST_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_state <= ST_IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else if (tx_state == ST_IDLE) begin
      if (!tx_empty) begin
        tx_state <= ST_START;
        tx_shift <= tx_dout;
        tx_timer <= div;
        uart_txd <= 1'b0;
      end
    end else if (tx_timer != '0) begin
      tx_timer <= tx_timer - DIV_W'(1);
    end else begin
      tx_timer <= div;
      case (tx_state)
        ST_START: begin
          tx_state <= ST_DATA;
          tx_bit   <= '0;
          uart_txd <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
        end
        ST_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_state <= ST_STOP;
            uart_txd <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            uart_txd <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end
        default: begin
          // End of stop bit: chain straight into the next frame if queued
          if (!tx_empty) begin
            tx_state <= ST_START;
            tx_shift <= tx_dout;
            uart_txd <= 1'b0;
          end else begin
            tx_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // RX engine
  logic [1:0]        rx_sync;
  logic              rx_s;
  uart_state_t       rx_state;
  logic [DIV_W-1:0]  rx_timer;
  logic [2:0]        rx_bit;
  logic              rx_stop_smp;
  logic              ferr_set;

  assign rx_s        = rx_sync[1];
  assign rx_stop_smp = (rx_state == ST_STOP) & (rx_timer == '0);
  assign rx_push     = rx_stop_smp & rx_s;
  assign ferr_set    = rx_stop_smp & ~rx_s;
  assign rx_pop      = rd_udr & ~rx_empty;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_sync  <= 2'b11;
      rx_state <= ST_IDLE;
      rx_timer <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rxd};
      if (rx_state == ST_IDLE) begin
        if (!rx_s) begin
          rx_state <= ST_START;
          rx_timer <= div >> 1;
        end
      end else if (rx_timer != '0) begin
        rx_timer <= rx_timer - DIV_W'(1);
      end else begin
        rx_timer <= div;
        case (rx_state)
          ST_START: begin
            // Line back high at mid start bit: treat as a glitch
            rx_state <= rx_s ? ST_IDLE : ST_DATA;
            rx_bit   <= '0;
          end
          ST_DATA: begin
            rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end
          default: rx_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Divisor, control and sticky status; a set on the same edge beats W1C
  logic rxovf_set, txovf_set;

  assign rxovf_set = rx_push & rx_full & ~rx_pop;
  assign txovf_set = wr_udr & tx_full & ~tx_pop;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div      <= DIV_RST;
      txie     <= 1'b0;
      rxovf    <= 1'b0;
      ferr     <= 1'b0;
      txovf    <= 1'b0;
      uart_irq <= 1'b0;
    end else begin
      if (wr_ubrl) div[7:0]  <= IO_WData;
      if (wr_ubrh) div[15:8] <= IO_WData;
      if (wr_usr)  txie      <= IO_WData[USR_TXIE];
      rxovf    <= rxovf_set | (rxovf & ~(wr_usr & IO_WData[USR_RXOVF]));
      ferr     <= ferr_set  | (ferr  & ~(wr_usr & IO_WData[USR_FERR]));
      txovf    <= txovf_set | (txovf & ~(wr_usr & IO_WData[USR_TXOVF]));
      uart_irq <= ~rx_empty | (txie & tx_idle);
    end
  end

  // Read mux, purely combinational on IO_Addr
  usr_t usr;

  always_comb begin
    usr        = '0;
    usr.rxne   = ~rx_empty;
    usr.txnf   = ~tx_full;
    usr.txidle = tx_idle;
    usr.rxovf  = rxovf;
    usr.ferr   = ferr;
    usr.txovf  = txovf;
    usr.txie   = txie;
  end

  always_comb begin
    IO_RData = '0;
    if (sel) begin
      case (off)
        OFF_UDR:  IO_RData = rx_empty ? '0 : rx_dout;
        OFF_USR:  IO_RData = usr;
        OFF_UBRL: IO_RData = div[7:0];
        OFF_UBRH: IO_RData = div[15:8];
        default:  IO_RData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mf8_io_uart.sv
// tb_mf8_io_uart: self-checking bench for mf8_io_uart (default parameters).
module tb_mf8_io_uart;

  localparam logic [5:0] A_UDR  = 6'h0C;
  localparam logic [5:0] A_USR  = 6'h0D;
  localparam logic [5:0] A_UBRL = 6'h0E;
  localparam logic [5:0] A_UBRH = 6'h0F;
  localparam int         RX_DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       IO_Rd, IO_Wr;
  logic [5:0] IO_Addr;
  logic [7:0] IO_WData;
  logic [7:0] IO_RData;
  logic       uart_rxd;
  logic       uart_txd;
  logic       uart_irq;

  mf8_io_uart dut (
    .Clk(Clk), .Reset_n(Reset_n), .IO_Rd(IO_Rd), .IO_Wr(IO_Wr),
    .IO_Addr(IO_Addr), .IO_WData(IO_WData), .IO_RData(IO_RData),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd), .uart_irq(uart_irq)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge Clk);
    IO_Addr = a; IO_WData = d; IO_Wr = 1'b1;
    @(posedge Clk); #1;
    IO_Wr = 1'b0;
  endtask

  task automatic io_read(input logic [5:0] a, output logic [7:0] d);
    @(negedge Clk);
    IO_Addr = a; IO_Rd = 1'b1;
    #1 d = IO_RData;
    @(posedge Clk); #1;
    IO_Rd = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [5:0] a, input logic [7:0] exp);
    logic [7:0] d;
    io_read(a, d);
    check8(name, d, exp);
  endtask

  // Line capture: one txd sample per clock, taken 2 time units after the edge
  logic cap_en = 1'b0;
  logic txq[$];
  initial forever begin
    @(posedge Clk); #2;
    if (cap_en) txq.push_back(uart_txd);
  end

  // Reference line: one idle sample, then each frame as 10 bits of DIV+1 clocks
  logic [7:0] tx_bytes[$];
  logic       exp_line[$];

  function automatic void build_line(input int div, input int trail);
    logic [9:0] f;
    exp_line.delete();
    exp_line.push_back(1'b1);
    foreach (tx_bytes[k]) begin
      f = {1'b1, tx_bytes[k], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int c = 0; c <= div; c++) exp_line.push_back(f[b]);
    end
    for (int t = 0; t < trail; t++) exp_line.push_back(1'b1);
  endfunction

  task automatic wait_and_compare(input string name);
    int budget;
    budget = 0;
    while (txq.size() < exp_line.size() && budget < 5000) begin
      @(posedge Clk); #3;
      budget++;
    end
    cap_en = 1'b0;
    if (txq.size() < exp_line.size()) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %0d samples want %0d", name, txq.size(), exp_line.size());
    end else begin
      foreach (exp_line[i]) check8($sformatf("%s[%0d]", name, i), 8'(txq[i]), 8'(exp_line[i]));
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (div + 1) @(negedge Clk);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] rx_model[$];
  logic [7:0] d, b, exp0;
  logic       ovf;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; IO_Rd = 1'b0; IO_Wr = 1'b0; IO_Addr = '0; IO_WData = '0; uart_rxd = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check8("rst_txd", 8'(uart_txd), 8'h01);
    check8("rst_irq", 8'(uart_irq), 8'h00);
    @(negedge Clk); Reset_n = 1'b1;

    // Register map table
    tbl.push_back('{1'b0, A_USR,  8'h00, 8'h06, "usr_rst"});
    tbl.push_back('{1'b0, A_UBRL, 8'h00, 8'hB1, "ubrl_rst"});
    tbl.push_back('{1'b0, A_UBRH, 8'h00, 8'h01, "ubrh_rst"});
    tbl.push_back('{1'b0, A_UDR,  8'h00, 8'h00, "udr_empty"});
    tbl.push_back('{1'b0, 6'h10,  8'h00, 8'h00, "out_hi"});
    tbl.push_back('{1'b0, 6'h0B,  8'h00, 8'h00, "out_lo"});
    tbl.push_back('{1'b0, 6'h3F,  8'h00, 8'h00, "out_top"});
    tbl.push_back('{1'b1, A_USR,  8'h7F, 8'h00, ""});
    tbl.push_back('{1'b0, A_USR,  8'h00, 8'h46, "usr_txie"});
    tbl.push_back('{1'b1, A_USR,  8'h00, 8'h00, ""});
    tbl.push_back('{1'b0, A_USR,  8'h00, 8'h06, "usr_txie_clr"});
    tbl.push_back('{1'b1, A_UBRL, 8'h34, 8'h00, ""});
    tbl.push_back('{1'b1, A_UBRH, 8'h12, 8'h00, ""});
    tbl.push_back('{1'b0, A_UBRL, 8'h00, 8'h34, "ubrl_wr"});
    tbl.push_back('{1'b0, A_UBRH, 8'h00, 8'h12, "ubrh_wr"});
    tbl.push_back('{1'b1, 6'h10,  8'hFF, 8'h00, ""});
    tbl.push_back('{1'b1, 6'h08,  8'hFF, 8'h00, ""});
    tbl.push_back('{1'b0, A_UBRL, 8'h00, 8'h34, "ubrl_keep"});
    tbl.push_back('{1'b0, A_USR,  8'h00, 8'h06, "usr_keep"});
    tbl.push_back('{1'b1, A_UBRL, 8'h03, 8'h00, ""});
    tbl.push_back('{1'b1, A_UBRH, 8'h00, 8'h00, ""});
    tbl.push_back('{1'b0, A_UBRL, 8'h00, 8'h03, "ubrl_3"});
    foreach (tbl[i]) begin
      if (tbl[i].wr) io_write(tbl[i].addr, tbl[i].data);
      else rd_check(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // Interrupt from TXIE & TXIDLE
    io_write(A_USR, 8'h40);
    @(posedge Clk); #1;
    check8("irq_txie", 8'(uart_irq), 8'h01);
    io_write(A_USR, 8'h00);
    @(posedge Clk); #1;
    check8("irq_txie_off", 8'(uart_irq), 8'h00);

    // Single TX frame 8'hA5, DIV=3
    tx_bytes.delete(); tx_bytes.push_back(8'hA5);
    build_line(3, 3);
    txq.delete();
    io_write(A_UDR, 8'hA5);
    cap_en = 1'b1;
    io_read(A_USR, d);
    check8("tx_busy_txidle", 8'(d[2]), 8'h00);
    wait_and_compare("tx_a5");
    rd_check("tx_done_usr", A_USR, 8'h06);

    // Burst of 5 random bytes plus an overflowing 6th
    tx_bytes.delete();
    for (int i = 0; i < 5; i++) tx_bytes.push_back(8'($urandom));
    build_line(3, 10);
    txq.delete();
    io_write(A_UDR, tx_bytes[0]);
    cap_en = 1'b1;
    for (int i = 1; i < 5; i++) io_write(A_UDR, tx_bytes[i]);
    io_write(A_UDR, 8'($urandom));
    rd_check("txovf_set", A_USR, 8'h20);
    wait_and_compare("tx_burst");
    io_write(A_USR, 8'h20);
    rd_check("txovf_w1c", A_USR, 8'h06);

    // RX single frame 8'h3C, DIV=7
    io_write(A_UBRL, 8'h07);
    @(negedge Clk);
    send_frame(8'h3C, 1'b1, 7);
    uart_rxd = 1'b1;
    repeat (4) @(posedge Clk);
    rd_check("rx_rxne", A_USR, 8'h07);
    #1 check8("rx_irq", 8'(uart_irq), 8'h01);
    rd_check("rx_data", A_UDR, 8'h3C);
    rd_check("rx_empty", A_USR, 8'h06);

    // RX overflow: 5 frames into a 4-deep FIFO
    rx_model.delete(); ovf = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (rx_model.size() < RX_DEPTH) rx_model.push_back(b); else ovf = 1'b1;
      send_frame(b, 1'b1, 7);
    end
    uart_rxd = 1'b1;
    repeat (4) @(posedge Clk);
    rd_check("rx_ovf_usr", A_USR, {4'b0000, ovf, 3'b111});
    for (int i = 0; i < 5; i++) begin
      exp0 = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
      rd_check($sformatf("rx_ovf_rd%0d", i), A_UDR, exp0);
    end
    io_write(A_USR, 8'h08);
    rd_check("rxovf_w1c", A_USR, 8'h06);

    // Full RX FIFO: UDR pop on the same edge as the 5th push, nothing lost
    rx_model.delete();
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      rx_model.push_back(b);
      send_frame(b, 1'b1, 7);
    end
    exp0 = rx_model.pop_front();
    b = 8'($urandom);
    rx_model.push_back(b);
    fork
      send_frame(b, 1'b1, 7);
      begin
        logic [7:0] dd;
        repeat (77) @(negedge Clk);
        io_read(A_UDR, dd);
        check8("rx_simul_pop", dd, exp0);
      end
    join
    uart_rxd = 1'b1;
    repeat (4) @(posedge Clk);
    rd_check("rx_simul_usr", A_USR, 8'h07);
    for (int i = 0; i < 5; i++) begin
      exp0 = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
      rd_check($sformatf("rx_simul_rd%0d", i), A_UDR, exp0);
    end

    // Framing error: stop bit 0, byte discarded
    @(negedge Clk);
    send_frame(8'($urandom), 1'b0, 7);
    uart_rxd = 1'b1;
    repeat (12) @(posedge Clk);
    rd_check("ferr_usr", A_USR, 8'h16);
    io_write(A_USR, 8'h10);
    rd_check("ferr_w1c", A_USR, 8'h06);

    // One-clock low glitch on rxd
    @(negedge Clk); uart_rxd = 1'b0;
    @(negedge Clk); uart_rxd = 1'b1;
    repeat (20) @(posedge Clk);
    rd_check("glitch_usr", A_USR, 8'h06);
    rd_check("glitch_udr", A_UDR, 8'h00);

    // Reset mid-frame: txd released asynchronously, state back to reset values
    io_write(A_UBRL, 8'h03);
    io_write(A_UDR, 8'h00);
    repeat (10) @(posedge Clk);
    #1 check8("mid_txd_low", 8'(uart_txd), 8'h00);
    @(negedge Clk); #2 Reset_n = 1'b0;
    #1 check8("async_rst_txd", 8'(uart_txd), 8'h01);
    @(negedge Clk); Reset_n = 1'b1;
    rd_check("post_rst_usr", A_USR, 8'h06);
    rd_check("post_rst_ubrl", A_UBRL, 8'hB1);
    rd_check("post_rst_ubrh", A_UBRH, 8'h01);
    repeat (10) @(posedge Clk);
    #1 check8("post_rst_txd", 8'(uart_txd), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
